// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg: register map, CTRL bit positions and shared helpers for
// the multi-channel deadline scheduler (timer_sched).
package timer_sched_pkg;

  // Per-channel register word offsets, selected by adr[3:2]
  localparam logic [1:0] REG_DL_LO  = 2'd0;
  localparam logic [1:0] REG_DL_HI  = 2'd1;
  localparam logic [1:0] REG_PERIOD = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  // Global register word offsets, selected by adr[6:2] when adr[7]=1
  localparam logic [4:0] G_STATUS = 5'd0;
  localparam logic [4:0] G_SCAN   = 5'd1;

  // CTRL register bit positions
  localparam int CTRL_ARM = 0;
  localparam int CTRL_IE  = 1;

  typedef logic [63:0] deadline_t;

  // Width of the channel index; a single channel still needs one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/timer_sched_scan.sv
// timer_sched_scan: round-robin channel pointer and the single shared 64-bit
// deadline comparator. With TIMER_SCHED_PERIODIC_EN defined it also forms
// the reload value (old deadline + period) for the channel under test.
module timer_sched_scan
  import timer_sched_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int IDXW = idx_width(NCH)
) (
  input  logic            wb_clk,
  input  logic            wb_rst,
  input  logic [63:0]     mtime,
  input  deadline_t       deadline [NCH],
  input  logic [NCH-1:0]  armed,
`ifdef TIMER_SCHED_PERIODIC_EN
  input  logic [31:0]     period [NCH],
  output logic            reload_en,
  output deadline_t       reload,
`endif
  output logic [IDXW-1:0] idx,
  output logic            hit,
  output logic [IDXW-1:0] hit_idx
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

  // Advance the scan pointer every cycle, wrapping after the last channel
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      idx <= '0;
    end else if (idx == LAST_IDX) begin
      idx <= '0;
    end else begin
      idx <= idx + IDXW'(1);
    end
  end

  // Shared unsigned comparator against the channel currently pointed at
  always_comb begin
    hit = armed[idx] && (mtime >= deadline[idx]);
  end

  assign hit_idx = idx;

`ifdef TIMER_SCHED_PERIODIC_EN
  // Reload from the old deadline (not mtime) so periodic channels never drift
  always_comb begin
    reload_en = (period[idx] != 32'd0);
    reload    = deadline[idx] + {32'b0, period[idx]};
  end
`endif

endmodule

// File: rtl/timer_sched.sv
// timer_sched: NCH-channel deadline scheduler on top of the 64-bit mtime
// counter. Bus decode, per-channel deadline/ctrl registers, pending flags
// and registered interrupt outputs. The comparator lives in timer_sched_scan.
// Optional feature macro: TIMER_SCHED_PERIODIC_EN (periodic auto-reload via
// the PERIOD register; when undefined every channel is one-shot).
module timer_sched
  import timer_sched_pkg::*;
#(
  parameter int NCH = 4
) (
  input  logic           wb_clk,
  input  logic           wb_rst,
  input  logic [63:0]    mtime,
  input  logic [31:0]    wb_dbus_dat,
  input  logic [31:0]    wb_dbus_adr,
  input  logic           wb_dbus_we,
  input  logic           cyc,
  output logic [31:0]    rdt,
  output logic           irq,
  output logic [NCH-1:0] ch_irq
);

  localparam int IDXW = idx_width(NCH);

  deadline_t       deadline [NCH];
  logic [31:0]     temp_lo;
  logic [NCH-1:0]  armed;
  logic [NCH-1:0]  ie;
  logic [NCH-1:0]  pending;

`ifdef TIMER_SCHED_PERIODIC_EN
  logic [31:0]     period [NCH];
  logic            reload_en;
  deadline_t       reload;
  logic [NCH-1:0]  per_wr;
`endif

  logic [IDXW-1:0] idx;
  logic [IDXW-1:0] hit_idx;
  logic            hit;

  // Address fields; only adr[7:2] take part in decode
  logic [2:0]      ch;
  logic [1:0]      word;
  logic [4:0]      gword;
  logic            glob;
  logic            ch_ok;
  logic            bus_wr;
  logic            bus_rd;
  logic            unused_adr;

  assign ch         = wb_dbus_adr[6:4];
  assign word       = wb_dbus_adr[3:2];
  assign gword      = wb_dbus_adr[6:2];
  assign glob       = wb_dbus_adr[7];
  assign ch_ok      = ({1'b0, ch} < 4'(NCH));
  assign bus_wr     = cyc & wb_dbus_we;
  assign bus_rd     = cyc & ~wb_dbus_we;
  assign unused_adr = ^{wb_dbus_adr[31:8], wb_dbus_adr[1:0]};

  logic            lo_wr;
  logic            w1c_wr;
  logic [NCH-1:0]  dlhi_wr;
  logic [NCH-1:0]  ctrl_wr;
  logic [NCH-1:0]  take_hit;

  assign lo_wr  = bus_wr && !glob && ch_ok && (word == REG_DL_LO);
  assign w1c_wr = bus_wr && glob && (gword == G_STATUS);

  timer_sched_scan #(
    .NCH  (NCH),
    .IDXW (IDXW)
  ) u_scan (
    .wb_clk    (wb_clk),
    .wb_rst    (wb_rst),
    .mtime     (mtime),
    .deadline  (deadline),
    .armed     (armed),
`ifdef TIMER_SCHED_PERIODIC_EN
    .period    (period),
    .reload_en (reload_en),
    .reload    (reload),
`endif
    .idx       (idx),
    .hit       (hit),
    .hit_idx   (hit_idx)
  );

  // Per-channel write strobes; a DL_HI or CTRL write to the scanned channel
  // discards that cycle's hit so software always sees its own update
  always_comb begin
    dlhi_wr  = '0;
    ctrl_wr  = '0;
    take_hit = '0;
`ifdef TIMER_SCHED_PERIODIC_EN
    per_wr   = '0;
`endif
    for (int i = 0; i < NCH; i++) begin
      if (bus_wr && !glob && (ch == 3'(i))) begin
        dlhi_wr[i] = (word == REG_DL_HI);
        ctrl_wr[i] = (word == REG_CTRL);
`ifdef TIMER_SCHED_PERIODIC_EN
        per_wr[i]  = (word == REG_PERIOD);
`endif
      end
      take_hit[i] = hit && (hit_idx == IDXW'(i)) && !dlhi_wr[i] && !ctrl_wr[i];
    end
  end

  // Deadline, arm/enable and pending state; a hit beats a same-cycle W1C
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      for (int i = 0; i < NCH; i++) begin
        deadline[i] <= '0;
      end
      temp_lo <= '0;
      armed   <= '0;
      ie      <= '0;
      pending <= '0;
    end else begin
      if (lo_wr) begin
        temp_lo <= wb_dbus_dat;
      end
      for (int i = 0; i < NCH; i++) begin
        if (dlhi_wr[i]) begin
          deadline[i] <= {wb_dbus_dat, temp_lo};
        end
        if (ctrl_wr[i]) begin
          armed[i] <= wb_dbus_dat[CTRL_ARM];
          ie[i]    <= wb_dbus_dat[CTRL_IE];
        end
        if (take_hit[i]) begin
          pending[i] <= 1'b1;
`ifdef TIMER_SCHED_PERIODIC_EN
          if (reload_en) begin
            deadline[i] <= reload;
          end else begin
            armed[i] <= 1'b0;
          end
`else
          armed[i] <= 1'b0;
`endif
        end else if (w1c_wr && wb_dbus_dat[i]) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

`ifdef TIMER_SCHED_PERIODIC_EN
  // Period registers, written only through the channel's PERIOD word
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      for (int i = 0; i < NCH; i++) begin
        period[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (per_wr[i]) begin
          period[i] <= wb_dbus_dat;
        end
      end
    end
  end
`endif

  // Registered interrupts, one cycle behind the pending flags
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      ch_irq <= '0;
      irq    <= 1'b0;
    end else begin
      ch_irq <= pending & ie;
      irq    <= |(pending & ie);
    end
  end

  // Read mux; zero whenever the access is not a read or hits nothing mapped
  always_comb begin
    rdt = '0;
    if (bus_rd) begin
      if (glob) begin
        if (gword == G_STATUS) begin
          rdt[NCH-1:0] = pending;
        end else if (gword == G_SCAN) begin
          rdt[IDXW-1:0] = idx;
        end
      end else begin
        for (int i = 0; i < NCH; i++) begin
          if (ch == 3'(i)) begin
            case (word)
              REG_DL_LO: rdt = deadline[i][31:0];
              REG_DL_HI: rdt = deadline[i][63:32];
`ifdef TIMER_SCHED_PERIODIC_EN
              REG_PERIOD: rdt = period[i];
`endif
              REG_CTRL: begin
                rdt[CTRL_ARM] = armed[i];
                rdt[CTRL_IE]  = ie[i];
              end
              default: rdt = '0;
            endcase
          end
        end
      end
    end
  end

endmodule
